// File: rtl/mp_cache_tag_ctrl_pkg.sv
// Shared constants and types for the cache tag SRAM port controller.
package mp_cache_tag_pkg;

  localparam int IDX_W   = 4;
  localparam int TAG_W   = 22;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int WORD_W  = TAG_W + 2;

  typedef struct packed {
    logic             v;
    logic             d;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    INIT,
    DISARM,
    RUN
  } tag_state_t;

endpackage

// File: rtl/mp_cache_tag_ctrl_if.sv
// Request/response bundle between the cache pipeline and the tag controller.
import mp_cache_tag_pkg::*;

interface mp_cache_tag_ctrl_if;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_v;
  logic             req_d;
  logic             rsp_valid;
  logic             rsp_stall;
  logic             rsp_hit;
  logic             rsp_v;
  logic             rsp_d;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_we, req_idx, req_tag, req_v, req_d, rsp_stall,
    input  req_ready, rsp_valid, rsp_hit, rsp_v, rsp_d, rsp_tag
  );

  modport slave (
    input  req_valid, req_we, req_idx, req_tag, req_v, req_d, rsp_stall,
    output req_ready, rsp_valid, rsp_hit, rsp_v, rsp_d, rsp_tag
  );
endinterface

// File: rtl/mp_cache_tag_ctrl.sv
// Port controller for the 16-entry tag SRAM macro: clear sweep after reset or
// flush, lookup/update requests, and a disarm read that stops the macro from
// repeating a latched write while the port sits idle.
//
//   state  | meaning
//   INIT   | writing zero to entry cnt, one entry per cycle
//   DISARM | read of the last entry to drop the macro's latched write enable
//   RUN    | accepting requests
import mp_cache_tag_pkg::*;

module mp_cache_tag_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  mp_cache_tag_ctrl_if.slave bus,
  output logic              busy,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [IDX_W-1:0]  sram_addr,
  output logic [WORD_W-1:0] sram_din,
  input  logic [WORD_W-1:0] sram_dout
);

  tag_state_t       state, state_nx;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] last_idx;
  logic             wr_pend;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] cmp_tag;
  logic             accept;
  tag_entry_t       rd_entry;

  assign bus.req_ready = !rst && (state == RUN) && !flush && !(rsp_valid_q && bus.rsp_stall);
  assign accept        = bus.req_valid && bus.req_ready;

  // Read data comes straight off the macro; it stays put while csb is high.
  assign rd_entry      = tag_entry_t'(sram_dout);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_v     = rd_entry.v;
  assign bus.rsp_d     = rd_entry.d;
  assign bus.rsp_tag   = rd_entry.tag;
  assign bus.rsp_hit   = rd_entry.v && (rd_entry.tag == cmp_tag);

  // Next state and SRAM pin drive; pins default to an idle port.
  always_comb begin
    state_nx  = state;
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    busy      = 1'b1;
    if (!rst) begin
      busy = (state != RUN);
      case (state)
        INIT: begin
          sram_csb  = 1'b0;
          sram_web  = 1'b0;
          sram_addr = cnt;
          if (cnt == {IDX_W{1'b1}}) state_nx = DISARM;
        end
        DISARM: begin
          sram_csb  = 1'b0;
          sram_addr = {IDX_W{1'b1}};
          state_nx  = RUN;
        end
        RUN: begin
          if (accept) begin
            sram_csb  = 1'b0;
            sram_web  = !bus.req_we;
            sram_addr = bus.req_idx;
            sram_din  = {bus.req_v, bus.req_d, bus.req_tag};
          end else if (wr_pend) begin
            sram_csb  = 1'b0;
            sram_addr = last_idx;
          end
        end
        default: state_nx = INIT;
      endcase
      if (flush) state_nx = INIT;
    end
  end

  // State register, sweep counter, pending-write tracking and response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      cnt         <= '0;
      last_idx    <= '0;
      wr_pend     <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmp_tag     <= '0;
    end else begin
      state <= state_nx;

      if (flush)              cnt <= '0;
      else if (state == INIT) cnt <= cnt + 1'b1;

      // Any accepted access or the disarm read itself clears the latch.
      if (flush)       wr_pend <= 1'b0;
      else if (accept) wr_pend <= bus.req_we;
      else             wr_pend <= 1'b0;

      if (accept && bus.req_we)  last_idx <= bus.req_idx;
      if (accept && !bus.req_we) cmp_tag  <= bus.req_tag;

      if (flush)                      rsp_valid_q <= 1'b0;
      else if (accept && !bus.req_we) rsp_valid_q <= 1'b1;
      else if (!bus.rsp_stall)        rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp_cache_tag_ctrl.sv
// Bench for the tag SRAM controller, including a behavioural model of the
// macro that keeps repeating a latched write (with whatever data is on the
// din pins) until it sees a read.
import mp_cache_tag_pkg::*;

module tb_mp_cache_tag_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy, sram_csb, sram_web;
  logic [IDX_W-1:0]  sram_addr;
  logic [WORD_W-1:0] sram_din, sram_dout;

  mp_cache_tag_ctrl_if bus ();

  mp_cache_tag_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Macro model.
  logic [WORD_W-1:0] mem [ENTRIES];
  logic              we_l = 1'b0;
  logic [IDX_W-1:0]  addr_l = '0;
  logic [WORD_W-1:0] din_l = '0;

  always @(posedge clk) begin
    if (we_l) mem[addr_l] <= din_l;
    din_l <= sram_din;
    if (!sram_csb) begin
      we_l   <= !sram_web;
      addr_l <= sram_addr;
    end
  end
  assign sram_dout = mem[addr_l];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_idx   = '0;
    bus.req_tag   = '0;
    bus.req_v     = 1'b0;
    bus.req_d     = 1'b0;
    bus.rsp_stall = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [IDX_W-1:0] idx,
                           input logic [TAG_W-1:0] tag, input logic v, input logic d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_idx   = idx;
    bus.req_tag   = tag;
    bus.req_v     = v;
    bus.req_d     = d;
  endtask

  // One accepted request, then the request lines go idle.
  task automatic issue(input logic we, input logic [IDX_W-1:0] idx,
                       input logic [TAG_W-1:0] tag, input logic v, input logic d);
    drive_req(we, idx, tag, v, d);
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'd1);
    next_cycle();
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic v, input logic d,
                            input logic [TAG_W-1:0] tag, input logic hit);
    @(negedge clk);
    check(name, {bus.rsp_valid, bus.rsp_v, bus.rsp_d, bus.rsp_hit, bus.rsp_tag},
                {1'b1, v, d, hit, tag});
    next_cycle();
  endtask

  typedef struct {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             v;
    logic             d;
    logic             exp_v;
    logic             exp_d;
    logic [TAG_W-1:0] exp_tag;
    logic             exp_hit;
  } vec_t;

  vec_t vecs [9];

  // Reference model state for the random phase.
  tag_entry_t sb [ENTRIES];
  tag_entry_t exp_entry;
  logic [TAG_W-1:0] exp_cmp;
  logic exp_rv;
  int   sweep_left;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_ready;
    logic exp_ready;
    logic exp_hit;

    for (int i = 0; i < ENTRIES; i++) mem[i] = WORD_W'($urandom);
    idle_inputs();

    vecs[0] = '{1'b1, 4'd5, 22'h2ABCDE, 1'b1, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0};
    vecs[1] = '{1'b0, 4'd5, 22'h2ABCDE, 1'b0, 1'b0, 1'b1, 1'b0, 22'h2ABCDE, 1'b1};
    vecs[2] = '{1'b0, 4'd5, 22'h2ABCDF, 1'b0, 1'b0, 1'b1, 1'b0, 22'h2ABCDE, 1'b0};
    vecs[3] = '{1'b1, 4'd9, 22'h000123, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0};
    vecs[4] = '{1'b0, 4'd9, 22'h000123, 1'b0, 1'b0, 1'b1, 1'b1, 22'h000123, 1'b1};
    vecs[5] = '{1'b1, 4'd9, 22'h000123, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0};
    vecs[6] = '{1'b0, 4'd9, 22'h000123, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000123, 1'b0};
    vecs[7] = '{1'b0, 4'd4, 22'h2ABCDE, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0};
    vecs[8] = '{1'b0, 4'd5, 22'h0,      1'b0, 1'b0, 1'b1, 1'b0, 22'h2ABCDE, 1'b0};

    // Reset pins and sweep timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pins", {sram_csb, sram_web, bus.req_ready, busy, bus.rsp_valid},
                        {1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    next_cycle();
    rst = 1'b0;
    first_ready = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0)
        check("init_pins", {sram_csb, sram_web, sram_addr, sram_din, busy},
                           {1'b0, 1'b0, 4'd0, 24'd0, 1'b1});
      if (c == 16)
        check("disarm_pins", {sram_csb, sram_web, sram_addr, busy}, {1'b0, 1'b1, 4'd15, 1'b1});
      if (bus.req_ready && first_ready < 0) first_ready = c;
      next_cycle();
    end
    check("first_ready_cycle", 64'(first_ready), 64'd17);
    check("busy_after_sweep", 64'(busy), 64'd0);

    // Every entry cleared.
    for (int i = 0; i < ENTRIES; i++) begin
      issue(1'b0, IDX_W'(i), '0, 1'b0, 1'b0);
      expect_rsp("cleared_lookup", 1'b0, 1'b0, '0, 1'b0);
    end

    // Table vectors: writes followed by an idle cycle, lookups by their result.
    for (int k = 0; k < 9; k++) begin
      issue(vecs[k].we, vecs[k].idx, vecs[k].tag, vecs[k].v, vecs[k].d);
      if (vecs[k].we) begin
        @(negedge clk);
        check("write_no_rsp", 64'(bus.rsp_valid), 64'd0);
        next_cycle();
      end else begin
        expect_rsp("vec_lookup", vecs[k].exp_v, vecs[k].exp_d, vecs[k].exp_tag, vecs[k].exp_hit);
      end
    end

    // Write then lookup back-to-back on the same index.
    drive_req(1'b1, 4'd3, 22'h111111, 1'b1, 1'b0);
    next_cycle();
    drive_req(1'b0, 4'd3, 22'h111111, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_lookup_ready", 64'(bus.req_ready), 64'd1);
    next_cycle();
    bus.req_valid = 1'b0;
    expect_rsp("b2b_new_data", 1'b1, 1'b0, 22'h111111, 1'b1);

    // Write then idle: disarm read on the pins, then an idle port.
    issue(1'b1, 4'd3, 22'h222222, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_disarm_pins", {sram_csb, sram_web, sram_addr}, {1'b0, 1'b1, 4'd3});
    next_cycle();
    @(negedge clk);
    check("idle_after_disarm", 64'(sram_csb), 64'd1);
    next_cycle();
    next_cycle();
    issue(1'b0, 4'd3, 22'h222222, 1'b0, 1'b0);
    expect_rsp("write_survives_idle", 1'b1, 1'b1, 22'h222222, 1'b1);

    // Stalled response with a second lookup waiting.
    issue(1'b0, 4'd5, 22'h2ABCDE, 1'b0, 1'b0);
    drive_req(1'b0, 4'd3, 22'h222222, 1'b0, 1'b0);
    bus.rsp_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_hold", {bus.req_ready, bus.rsp_valid, bus.rsp_v, bus.rsp_hit, bus.rsp_tag},
                          {1'b0, 1'b1, 1'b1, 1'b1, 22'h2ABCDE});
      next_cycle();
    end
    bus.rsp_stall = 1'b0;
    @(negedge clk);
    check("stall_release", {bus.req_ready, bus.rsp_valid, bus.rsp_tag}, {1'b1, 1'b1, 22'h2ABCDE});
    next_cycle();
    bus.req_valid = 1'b0;
    expect_rsp("after_release", 1'b1, 1'b1, 22'h222222, 1'b1);
    @(negedge clk);
    check("rsp_drained", 64'(bus.rsp_valid), 64'd0);
    next_cycle();

    // Flush while a response is stalled.
    issue(1'b0, 4'd5, 22'h2ABCDE, 1'b0, 1'b0);
    bus.rsp_stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 64'(bus.req_ready), 64'd0);
    next_cycle();
    flush = 1'b0;
    bus.rsp_stall = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      @(negedge clk);
      if (k == 0) check("flush_drops_rsp", {bus.rsp_valid, busy}, {1'b0, 1'b1});
      check("flush_sweep", {sram_csb, sram_web, sram_addr, sram_din}, {1'b0, 1'b0, 4'(k), 24'd0});
      next_cycle();
    end
    @(negedge clk);
    check("flush_disarm", {sram_csb, sram_web, sram_addr, bus.req_ready},
                          {1'b0, 1'b1, 4'd15, 1'b0});
    next_cycle();
    @(negedge clk);
    check("flush_ready", {bus.req_ready, busy}, {1'b1, 1'b0});
    next_cycle();
    issue(1'b0, 4'd5, 22'h2ABCDE, 1'b0, 1'b0);
    expect_rsp("flushed_miss", 1'b0, 1'b0, '0, 1'b0);

    // Random phase against the scoreboard.
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) sb[i] = '0;
    sweep_left = 17;
    exp_rv = 1'b0;
    exp_entry = '0;
    exp_cmp = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.req_valid = ($urandom % 4) != 0;
      bus.req_we    = ($urandom % 3) == 0;
      bus.req_idx   = IDX_W'($urandom);
      bus.req_tag   = 22'h15A000 + TAG_W'($urandom % 4);
      bus.req_v     = 1'($urandom);
      bus.req_d     = 1'($urandom);
      bus.rsp_stall = ($urandom % 10) == 0;
      flush         = ($urandom % 10) == 0;
      @(negedge clk);
      exp_ready = (sweep_left == 0) && !flush && !(exp_rv && bus.rsp_stall);
      check("rand_ctl", {bus.req_ready, busy, bus.rsp_valid},
                        {exp_ready, sweep_left != 0, exp_rv});
      if (exp_rv) begin
        exp_hit = exp_entry.v && (exp_entry.tag == exp_cmp);
        check("rand_rsp", {bus.rsp_v, bus.rsp_d, bus.rsp_hit, bus.rsp_tag},
                          {exp_entry.v, exp_entry.d, exp_hit, exp_entry.tag});
      end
      if (flush) begin
        exp_rv = 1'b0;
        sweep_left = 17;
        for (int i = 0; i < ENTRIES; i++) sb[i] = '0;
      end else begin
        if (sweep_left > 0) sweep_left--;
        if (bus.req_valid && exp_ready && !bus.req_we) begin
          exp_rv    = 1'b1;
          exp_entry = sb[bus.req_idx];
          exp_cmp   = bus.req_tag;
        end else if (bus.req_valid && exp_ready) begin
          sb[bus.req_idx] = '{v: bus.req_v, d: bus.req_d, tag: bus.req_tag};
          exp_rv = 1'b0;
        end else if (!bus.rsp_stall) begin
          exp_rv = 1'b0;
        end
      end
      next_cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
